// File: rtl/sramgen_sram_model_v2.sv
// Behavioural SRAM macro model: post-reset clear sequence, chip-enable gating,
// per-lane write mask, pipelined read path with valid strobe, optional write-through.
module sramgen_sram_model_v2 #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int WMASK_WIDTH   = 4,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_THROUGH = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   ready,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   sae_int
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int MW        = DATA_WIDTH / WMASK_WIDTH;

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_err_mask
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_err_lat
        $error("READ_LATENCY must be in 1..4");
    end
    if (ADDR_WIDTH < 1) begin : g_err_addr
        $error("ADDR_WIDTH must be at least 1");
    end

    typedef enum logic {S_CLEAR, S_READY} state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0]  old_word,
        input logic [DATA_WIDTH-1:0]  new_word,
        input logic [WMASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int k = 0; k < WMASK_WIDTH; k++) begin
            if (mask[k]) merged[k*MW +: MW] = new_word[k*MW +: MW];
        end
        return merged;
    endfunction

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

    logic                   accept;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic                   vld_p0;
    logic [DATA_WIDTH-1:0]  data_p0;
    logic                   feed_vld;
    logic [DATA_WIDTH-1:0]  feed_data;

    // Stage p0: request accepted at this edge; read word or merged write word
    assign accept  = ready & ce & ~rst;
    assign rd_word = mem[addr];
    assign wr_word = merge_lanes(rd_word, din, wmask);
    assign vld_p0  = accept & (~we | (WRITE_THROUGH != 0));
    assign data_p0 = we ? wr_word : rd_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) mem[clr_cnt] <= '0;
            else if (accept && we) mem[addr] <= wr_word;
        end
    end

    // Stage p1..: extra delay stages; the last one feeds the output register
    if (READ_LATENCY == 1) begin : g_direct
        assign feed_vld  = vld_p0;
        assign feed_data = data_p0;
    end else begin : g_pipe
        logic [READ_LATENCY-2:0] vld_p1;
        logic [DATA_WIDTH-1:0]   data_p1 [READ_LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p1 <= '0;
            end else begin
                vld_p1[0] <= vld_p0;
                for (int k = 1; k < READ_LATENCY-1; k++) vld_p1[k] <= vld_p1[k-1];
            end
        end

        always_ff @(posedge clk) begin
            data_p1[0] <= data_p0;
            for (int k = 1; k < READ_LATENCY-1; k++) data_p1[k] <= data_p1[k-1];
        end

        assign feed_vld  = vld_p1[READ_LATENCY-2];
        assign feed_data = data_p1[READ_LATENCY-2];
    end

    // Output stage and control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            ready      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sae_int    <= 1'b0;
        end else begin
            dout_valid <= feed_vld;
            if (feed_vld) dout <= feed_data;
            sae_int <= accept & ~we;
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (&clr_cnt) begin
                        state <= S_READY;
                        ready <= 1'b1;
                    end
                end
                S_READY: ready <= 1'b1;
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_sramgen_sram_model_v2.sv
// Scoreboard bench: two model instances (latency 1 / no write-through, latency 3 / write-through)
// share one directed stimulus stream; monitors pop expected words and arrival edges.
module tb_sramgen_sram_model_v2;

    logic        clk = 1'b0;
    logic        rst, ce, we;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        ready0, dv0, sae0, ready1, dv1, sae1;
    logic [31:0] dout0, dout1;

    typedef struct {
        logic [31:0] d;
        int          e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    bit   sae_exp[int];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sramgen_sram_model_v2 #(.READ_LATENCY(1), .WRITE_THROUGH(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .ready(ready0), .dout(dout0), .dout_valid(dv0), .sae_int(sae0)
    );

    sramgen_sram_model_v2 #(.READ_LATENCY(3), .WRITE_THROUGH(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .ready(ready1), .dout(dout1), .dout_valid(dv1), .sae_int(sae1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one request; accept edge is the next posedge. req is the expected output word.
    task automatic op(input logic w, input logic [3:0] m, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] req);
        @(negedge clk);
        ce = 1'b1; we = w; wmask = m; addr = a; din = d;
        if (!w) begin
            q0.push_back('{req, cyc + 1});
            sae_exp[cyc + 1] = 1'b1;
        end
        q1.push_back('{req, cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (dv0 === 1'b1) begin
            if (q0.size() == 0) chk("dut0_spurious_valid", dv0, 0);
            else begin
                e0 = q0.pop_front();
                chk("dut0_dout", dout0, e0.d);
                chk("dut0_valid_edge", cyc, e0.e);
            end
        end
        if (sae0 === 1'b1 || sae_exp.exists(cyc)) chk("dut0_sae", sae0, sae_exp.exists(cyc));
    end

    always @(negedge clk) begin
        if (dv1 === 1'b1) begin
            if (q1.size() == 0) chk("dut1_spurious_valid", dv1, 0);
            else begin
                e1 = q1.pop_front();
                chk("dut1_dout", dout1, e1.d);
                chk("dut1_valid_edge", cyc, e1.e);
            end
        end
        if (sae1 === 1'b1 || sae_exp.exists(cyc)) chk("dut1_sae", sae1, sae_exp.exists(cyc));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; wmask = '0; addr = '0; din = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", ready0, 0);   chk("rst_ready1", ready1, 0);
        chk("rst_dout0", dout0, 0);     chk("rst_dout1", dout1, 0);
        chk("rst_valid0", dv0, 0);      chk("rst_valid1", dv1, 0);
        chk("rst_sae0", sae0, 0);       chk("rst_sae1", sae1, 0);

        // Write attempt held active during the whole clear sequence must be ignored
        ce = 1'b1; we = 1'b1; wmask = 4'hF; addr = 8'd5; din = 32'hFFFF_FFFF;
        rst = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (i == 1 || i == 255) begin
                chk("clear_ready0", ready0, 0);
                chk("clear_ready1", ready1, 0);
            end
            if (i == 255) ce = 1'b0;
            if (i == 256) begin
                chk("clear_done_ready0", ready0, 1);
                chk("clear_done_ready1", ready1, 1);
            end
        end

        for (int a = 0; a < 256; a++) op(1'b0, 4'h0, 8'(a), 32'h0, 32'h0);
        idle(4);

        op(1'b1, 4'b1111, 8'h10, 32'hAABB_CCDD, 32'hAABB_CCDD);
        op(1'b1, 4'b0101, 8'h10, 32'h1122_3344, 32'hAA22_CC44);
        op(1'b0, 4'h0,    8'h10, 32'h0,         32'hAA22_CC44);
        idle(4);

        for (int a = 1; a <= 4; a++) op(1'b1, 4'hF, 8'(a), 32'(a), 32'(a));
        for (int a = 1; a <= 4; a++) op(1'b0, 4'h0, 8'(a), 32'h0, 32'(a));
        idle(4);

        @(negedge clk);
        ce = 1'b0; we = 1'b1; wmask = 4'hF; addr = 8'd4; din = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("ce0_hold_dout0", dout0, 32'd4);
        chk("ce0_hold_dout1", dout1, 32'd4);
        op(1'b0, 4'h0, 8'd4, 32'h0, 32'd4);
        idle(4);

        op(1'b1, 4'hF, 8'd7, 32'h1234_5678, 32'h1234_5678);
        idle(3);
        op(1'b1, 4'b0011, 8'd7, 32'hDEAD_BEEF, 32'h1234_BEEF);
        idle(4);
        chk("wt0_dout_hold", dout0, 32'd4);
        chk("wt1_dout_merged", dout1, 32'h1234_BEEF);
        op(1'b0, 4'h0, 8'd7, 32'h0, 32'h1234_BEEF);
        idle(4);

        // Read in flight on the latency-3 instance, then reset before it emerges
        op(1'b0, 4'h0, 8'd7, 32'h0, 32'h1234_BEEF);
        @(negedge clk);
        rst = 1'b1; ce = 1'b0;
        q1.delete();
        @(negedge clk);
        chk("flush_dout0", dout0, 0);   chk("flush_dout1", dout1, 0);
        chk("flush_valid0", dv0, 0);    chk("flush_valid1", dv1, 0);
        chk("flush_ready0", ready0, 0); chk("flush_ready1", ready1, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (i == 255) begin
                chk("reclear_ready0", ready0, 0);
                chk("reclear_ready1", ready1, 0);
            end
            if (i == 256) begin
                chk("reclear_done_ready0", ready0, 1);
                chk("reclear_done_ready1", ready1, 1);
            end
        end
        op(1'b0, 4'h0, 8'd7,  32'h0, 32'h0);
        op(1'b0, 4'h0, 8'h10, 32'h0, 32'h0);
        op(1'b0, 4'h0, 8'd5,  32'h0, 32'h0);
        idle(6);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
